// File: rtl/opendap_ap_defs_pkg.sv
// Shared AP definitions: register offsets, CSW field layout and APB sequencer state encoding.
// Kept separate so future APs can import the same map.
package opendap_ap_defs_pkg;

  localparam logic [7:0] OffCsw = 8'h00;
  localparam logic [7:0] OffTar = 8'h04;
  localparam logic [7:0] OffDrw = 8'h0C;
  localparam logic [7:0] OffBd0 = 8'h10;
  localparam logic [7:0] OffBd3 = 8'h1C;
  localparam logic [7:0] OffIdr = 8'hFC;

  localparam int unsigned CswSizeLsb     = 0;
  localparam int unsigned CswAddrIncLsb  = 4;
  localparam int unsigned CswDeviceEnBit = 6;
  localparam int unsigned CswTrInProgBit = 7;

  localparam logic [2:0] CswSizeWord   = 3'b010;
  localparam logic [1:0] AddrIncOff    = 2'b00;
  localparam logic [1:0] AddrIncSingle = 2'b01;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } xfer_state_e;

  function automatic logic is_bd_offset(input logic [7:0] off);
    return (off >= OffBd0) && (off <= OffBd3);
  endfunction

  // Word increment that wraps inside the current 1KB block.
  function automatic logic [31:0] tar_inc(input logic [31:0] tar);
    return {tar[31:10], tar[9:2] + 8'd1, 2'b00};
  endfunction

endpackage

// File: rtl/opendap_apb_ap_xfer.sv
// APB master sequencer: IDLE -> SETUP -> ACCESS, with address/data latches and abort.
// Reports a single-cycle completion strobe on the edge where pready is seen in ACCESS.
module opendap_apb_ap_xfer
  import opendap_ap_defs_pkg::*;
(
  input  logic        swclk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_addr,
  input  logic        i_write,
  input  logic [31:0] i_wdata,
  input  logic        i_pready,
  output logic [31:0] o_paddr,
  output logic        o_psel,
  output logic        o_penable,
  output logic        o_pwrite,
  output logic [31:0] o_pwdata,
  output logic        o_idle,
  output logic        o_done
);

  xfer_state_e r_state;
  xfer_state_e w_state_next;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic        r_pwrite;

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
    end else if (i_start && (r_state == StIdle)) begin
      r_paddr  <= i_addr;
      r_pwdata <= i_wdata;
      r_pwrite <= i_write;
    end
  end

  // Abort wins over a coincident pready, so an aborted transfer never completes.
  always_comb begin
    w_state_next = r_state;
    o_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_next = StSetup;
      end
      StSetup: begin
        w_state_next = i_abort ? StIdle : StAccess;
      end
      StAccess: begin
        if (i_abort) begin
          w_state_next = StIdle;
        end else if (i_pready) begin
          w_state_next = StIdle;
          o_done       = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_psel    = (r_state != StIdle);
  assign o_penable = (r_state == StAccess);
  assign o_idle    = (r_state == StIdle);
  assign o_paddr   = r_paddr;
  assign o_pwdata  = r_pwdata;
  assign o_pwrite  = r_pwrite;

endmodule

// File: rtl/opendap_apb_mem_ap.sv
// APB memory access port: CSW/TAR/IDR register file and decode, with DRW/BD
// accesses forwarded to the APB sequencer.
module opendap_apb_mem_ap
  import opendap_ap_defs_pkg::*;
#(
  parameter logic [7:0]  APSEL = 8'h00,
  parameter logic [31:0] IDR   = 32'h0477_0002
) (
  input  logic        swclk,
  input  logic        rst_n,
  input  logic [7:0]  ap_sel,
  input  logic [5:0]  ap_addr,
  input  logic [31:0] ap_wdata,
  input  logic        ap_wen,
  input  logic        ap_ren,
  input  logic        ap_abort,
  output logic [31:0] ap_rdata,
  output logic        ap_rdy,
  output logic        ap_err,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  logic [1:0]  r_addr_inc;
  logic [31:0] r_tar;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_drw;
  logic        r_read;

  logic [7:0]  w_off;
  logic        w_strobe_ok;
  logic        w_accept;
  logic        w_unsel_rd;
  logic        w_is_drw;
  logic        w_is_bd;
  logic        w_is_mem;
  logic        w_reg_wr;
  logic        w_reg_rd;
  logic [31:0] w_mem_addr;
  logic [31:0] w_csw;
  logic [31:0] w_reg_rdata;
  logic        w_idle;
  logic        w_done;
  logic        w_tar_inc;

  assign w_off       = {ap_addr, 2'b00};
  assign w_strobe_ok = !ap_abort && ap_rdy;
  assign w_accept    = (ap_wen || ap_ren) && w_strobe_ok && (ap_sel == APSEL);
  assign w_unsel_rd  = ap_ren && w_strobe_ok && (ap_sel != APSEL);

  assign w_is_drw   = (w_off == OffDrw);
  assign w_is_bd    = is_bd_offset(w_off);
  assign w_is_mem   = w_is_drw || w_is_bd;
  assign w_reg_wr   = w_accept && !w_is_mem && ap_wen;
  assign w_reg_rd   = w_accept && !w_is_mem && !ap_wen;
  assign w_mem_addr = w_is_bd ? {r_tar[31:4], ap_addr[1:0], 2'b00} : r_tar;

  always_comb begin
    w_csw = '0;
    w_csw[CswSizeLsb +: 3]    = CswSizeWord;
    w_csw[CswAddrIncLsb +: 2] = r_addr_inc;
    w_csw[CswDeviceEnBit]     = 1'b1;
    w_csw[CswTrInProgBit]     = !w_idle;
  end

  always_comb begin
    w_reg_rdata = '0;
    case (w_off)
      OffCsw:  w_reg_rdata = w_csw;
      OffTar:  w_reg_rdata = r_tar;
      OffIdr:  w_reg_rdata = IDR;
      default: w_reg_rdata = '0;
    endcase
  end

  // Reserved AddrInc encodings behave as "off".
  assign w_tar_inc = w_done && !pslverr && r_drw && (r_addr_inc == AddrIncSingle);

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_inc <= AddrIncOff;
      r_tar      <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_drw      <= 1'b0;
      r_read     <= 1'b0;
    end else begin
      r_err <= w_done && pslverr;
      if (w_accept && w_is_mem) begin
        r_drw  <= w_is_drw;
        r_read <= !ap_wen;
      end
      if (w_reg_wr && (w_off == OffCsw)) begin
        r_addr_inc <= ap_wdata[CswAddrIncLsb +: 2];
      end
      if (w_reg_wr && (w_off == OffTar)) begin
        r_tar <= {ap_wdata[31:2], 2'b00};
      end else if (w_tar_inc) begin
        r_tar <= tar_inc(r_tar);
      end
      if (w_done && r_read) begin
        r_rdata <= prdata;
      end else if (w_reg_rd) begin
        r_rdata <= w_reg_rdata;
      end else if (w_unsel_rd) begin
        r_rdata <= '0;
      end
    end
  end

  opendap_apb_ap_xfer u_xfer (
    .swclk     (swclk),
    .rst_n     (rst_n),
    .i_start   (w_accept && w_is_mem),
    .i_abort   (ap_abort),
    .i_addr    (w_mem_addr),
    .i_write   (ap_wen),
    .i_wdata   (ap_wdata),
    .i_pready  (pready),
    .o_paddr   (paddr),
    .o_psel    (psel),
    .o_penable (penable),
    .o_pwrite  (pwrite),
    .o_pwdata  (pwdata),
    .o_idle    (w_idle),
    .o_done    (w_done)
  );

  assign ap_rdy   = w_idle;
  assign ap_err   = r_err;
  assign ap_rdata = r_rdata;

endmodule

// File: tb/tb_opendap_apb_mem_ap.sv
// Bench for opendap_apb_mem_ap: scoreboarded AP accesses against a simple APB slave model.
module tb_opendap_apb_mem_ap;

  localparam logic [7:0]  ApSel  = 8'h00;
  localparam logic [31:0] IdrVal = 32'h0477_0002;

  logic        swclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ap_sel = '0;
  logic [5:0]  ap_addr = '0;
  logic [31:0] ap_wdata = '0;
  logic        ap_wen = 1'b0;
  logic        ap_ren = 1'b0;
  logic        ap_abort = 1'b0;
  logic [31:0] ap_rdata;
  logic        ap_rdy;
  logic        ap_err;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  always #5 swclk = ~swclk;

  opendap_apb_mem_ap #(
    .APSEL (ApSel),
    .IDR   (IdrVal)
  ) dut (
    .swclk    (swclk),
    .rst_n    (rst_n),
    .ap_sel   (ap_sel),
    .ap_addr  (ap_addr),
    .ap_wdata (ap_wdata),
    .ap_wen   (ap_wen),
    .ap_ren   (ap_ren),
    .ap_abort (ap_abort),
    .ap_rdata (ap_rdata),
    .ap_rdy   (ap_rdy),
    .ap_err   (ap_err),
    .paddr    (paddr),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  // APB slave: pready after wait_n stalled ACCESS cycles, never while hold is set.
  int          acc_cnt = 0;
  int          wait_n = 0;
  logic        hold = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;

  assign pready  = penable && !hold && (acc_cnt == wait_n);
  assign prdata  = slv_rdata;
  assign pslverr = slv_err && pready;

  always @(posedge swclk or negedge rst_n) begin
    if (!rst_n) acc_cnt <= 0;
    else if (penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  int          done_cnt = 0;
  int          psel_cnt = 0;
  logic [31:0] mon_paddr = '0;
  logic [31:0] mon_pwdata = '0;
  logic        mon_pwrite = 1'b0;

  always @(posedge swclk) begin
    if (psel) psel_cnt <= psel_cnt + 1;
    if (psel && penable && pready) begin
      done_cnt   <= done_cnt + 1;
      mon_paddr  <= paddr;
      mon_pwdata <= pwdata;
      mon_pwrite <= pwrite;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  logic [31:0] obs_rdata;
  logic        obs_err;
  logic        obs_err2;
  int          obs_low;

  // Drives one strobe, waits (bounded) for ap_rdy, then captures outputs.
  task automatic ap_cmd(input logic [7:0] sel, input logic [5:0] addr,
                        input logic [31:0] wdata, input logic wr);
    @(posedge swclk); #1;
    ap_sel = sel; ap_addr = addr; ap_wdata = wdata; ap_wen = wr; ap_ren = !wr;
    @(posedge swclk); #1;
    ap_wen = 1'b0; ap_ren = 1'b0;
    obs_low = 0;
    @(negedge swclk);
    while (!ap_rdy && obs_low < 50) begin
      obs_low++;
      @(negedge swclk);
    end
    obs_rdata = ap_rdata;
    obs_err   = ap_err;
    @(negedge swclk);
    obs_err2 = ap_err;
  endtask

  task automatic test_reset();
    #2;
    total++; if (psel !== 1'b0 || penable !== 1'b0) begin
      bad++; $display("FAIL reset_psel: got %b%b want 00", psel, penable); end
    total++; if (ap_rdy !== 1'b1 || ap_err !== 1'b0) begin
      bad++; $display("FAIL reset_rdy_err: got %b%b want 10", ap_rdy, ap_err); end
    total++; if (ap_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want 0", ap_rdata); end
    total++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pwrite !== 1'b0) begin
      bad++; $display("FAIL reset_apb: got %h %h %b want 0", paddr, pwdata, pwrite); end
    @(negedge swclk); rst_n = 1'b1;
    exp_q.push_back('{rdata: 32'h0000_0042, err: 1'b0});
    ap_cmd(ApSel, 6'h00, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata) begin
      bad++; $display("FAIL reset_csw: got %h want %h", obs_rdata, e.rdata); end
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    ap_cmd(ApSel, 6'h01, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata || obs_low != 0) begin
      bad++; $display("FAIL reset_tar: got %h/%0d want %h/0", obs_rdata, obs_low, e.rdata); end
  endtask

  task automatic test_drw_write();
    int n0;
    ap_cmd(ApSel, 6'h01, 32'h2000_0000, 1'b1);
    ap_cmd(ApSel, 6'h00, 32'h0000_0010, 1'b1);
    exp_q.push_back('{rdata: 32'h0000_0052, err: 1'b0});
    ap_cmd(ApSel, 6'h00, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata) begin
      bad++; $display("FAIL csw_rd: got %h want %h", obs_rdata, e.rdata); end
    wait_n = 1; n0 = done_cnt;
    ap_cmd(ApSel, 6'h03, 32'hCAFE_F00D, 1'b1);
    total++; if (done_cnt != n0 + 1 || mon_paddr !== 32'h2000_0000) begin
      bad++; $display("FAIL drw_wr_paddr: got %h want 20000000", mon_paddr); end
    total++; if (mon_pwrite !== 1'b1 || mon_pwdata !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL drw_wr_data: got %b %h want 1 cafef00d", mon_pwrite, mon_pwdata); end
    total++; if (obs_low != 3 || obs_err !== 1'b0) begin
      bad++; $display("FAIL drw_wr_rdy: got %0d/%b want 3/0", obs_low, obs_err); end
    wait_n = 0;
    exp_q.push_back('{rdata: 32'h2000_0004, err: 1'b0});
    ap_cmd(ApSel, 6'h01, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata) begin
      bad++; $display("FAIL tar_inc: got %h want %h", obs_rdata, e.rdata); end
  endtask

  task automatic test_wrap();
    ap_cmd(ApSel, 6'h01, 32'h1000_03FC, 1'b1);
    slv_rdata = 32'h1234_5678;
    exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    ap_cmd(ApSel, 6'h03, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata || obs_err !== e.err || obs_low != 2) begin
      bad++; $display("FAIL drw_rd: got %h/%b/%0d want %h/%b/2", obs_rdata, obs_err, obs_low,
                      e.rdata, e.err); end
    exp_q.push_back('{rdata: 32'h1000_0000, err: 1'b0});
    ap_cmd(ApSel, 6'h01, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata) begin
      bad++; $display("FAIL tar_wrap: got %h want %h", obs_rdata, e.rdata); end
  endtask

  task automatic test_slverr();
    ap_cmd(ApSel, 6'h01, 32'h3000_0010, 1'b1);
    slv_err = 1'b1;
    exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b1});
    ap_cmd(ApSel, 6'h03, 32'h0, 1'b0);
    e = exp_q.pop_front();
    slv_err = 1'b0;
    total++; if (obs_err !== e.err || obs_err2 !== 1'b0) begin
      bad++; $display("FAIL slverr_pulse: got %b%b want 10", obs_err, obs_err2); end
    exp_q.push_back('{rdata: 32'h3000_0010, err: 1'b0});
    ap_cmd(ApSel, 6'h01, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata || obs_err !== e.err) begin
      bad++; $display("FAIL slverr_tar: got %h/%b want %h/0", obs_rdata, obs_err, e.rdata); end
  endtask

  task automatic test_abort();
    int n;
    ap_cmd(ApSel, 6'h01, 32'h5000_0000, 1'b1);
    ap_cmd(ApSel, 6'h00, 32'h0, 1'b0);
    hold = 1'b1;
    @(posedge swclk); #1;
    ap_sel = ApSel; ap_addr = 6'h03; ap_ren = 1'b1;
    @(posedge swclk); #1;
    ap_ren = 1'b0;
    n = 0;
    @(negedge swclk);
    while (!penable && n < 10) begin n++; @(negedge swclk); end
    @(negedge swclk);
    ap_abort = 1'b1;
    @(posedge swclk); #1;
    ap_abort = 1'b0;
    hold = 1'b0;
    total++; if (psel !== 1'b0 || penable !== 1'b0 || ap_rdy !== 1'b1 || ap_err !== 1'b0) begin
      bad++; $display("FAIL abort_state: got %b%b%b%b want 0010", psel, penable, ap_rdy, ap_err);
    end
    total++; if (ap_rdata !== 32'h0000_0052) begin
      bad++; $display("FAIL abort_rdata: got %h want 00000052", ap_rdata); end
    exp_q.push_back('{rdata: 32'h0000_0052, err: 1'b0});
    ap_cmd(ApSel, 6'h00, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata) begin
      bad++; $display("FAIL abort_csw: got %h want %h", obs_rdata, e.rdata); end
    exp_q.push_back('{rdata: 32'h5000_0000, err: 1'b0});
    ap_cmd(ApSel, 6'h01, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata) begin
      bad++; $display("FAIL abort_tar: got %h want %h", obs_rdata, e.rdata); end
  endtask

  task automatic test_idr_bd();
    exp_q.push_back('{rdata: IdrVal, err: 1'b0});
    ap_cmd(ApSel, 6'h3F, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata) begin
      bad++; $display("FAIL idr: got %h want %h", obs_rdata, e.rdata); end
    ap_cmd(ApSel, 6'h01, 32'h4000_000B, 1'b1);
    slv_rdata = 32'hA5A5_0002;
    exp_q.push_back('{rdata: 32'hA5A5_0002, err: 1'b0});
    ap_cmd(ApSel, 6'h06, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (mon_paddr !== 32'h4000_0008 || mon_pwrite !== 1'b0) begin
      bad++; $display("FAIL bd2_paddr: got %h/%b want 40000008/0", mon_paddr, mon_pwrite); end
    total++; if (obs_rdata !== e.rdata) begin
      bad++; $display("FAIL bd2_rdata: got %h want %h", obs_rdata, e.rdata); end
    exp_q.push_back('{rdata: 32'h4000_0008, err: 1'b0});
    ap_cmd(ApSel, 6'h01, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata) begin
      bad++; $display("FAIL bd2_tar: got %h want %h", obs_rdata, e.rdata); end
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    ap_cmd(ApSel, 6'h02, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata) begin
      bad++; $display("FAIL raz: got %h want %h", obs_rdata, e.rdata); end
  endtask

  task automatic test_unsel();
    int p0;
    ap_cmd(ApSel, 6'h3F, 32'h0, 1'b0);
    p0 = psel_cnt;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    ap_cmd(ApSel + 8'd1, 6'h03, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata || obs_low != 0 || psel_cnt != p0) begin
      bad++; $display("FAIL unsel: got %h/%0d/%0d want %h/0/%0d", obs_rdata, obs_low, psel_cnt,
                      e.rdata, p0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs[2];
    addrs[0] = 32'h6000_0000; addrs[1] = 32'h6000_0004;
    ap_cmd(ApSel, 6'h01, 32'h6000_0000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      ap_cmd(ApSel, 6'h03, 32'h1111_1111 * (i + 1), 1'b1);
      total++; if (mon_paddr !== addrs[i] || mon_pwdata !== 32'h1111_1111 * (i + 1)) begin
        bad++; $display("FAIL b2b_%0d: got %h %h want %h", i, mon_paddr, mon_pwdata, addrs[i]);
      end
    end
    exp_q.push_back('{rdata: 32'h6000_0008, err: 1'b0});
    ap_cmd(ApSel, 6'h01, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata) begin
      bad++; $display("FAIL b2b_tar: got %h want %h", obs_rdata, e.rdata); end
  endtask

  task automatic test_reset_mid();
    int n0;
    int n;
    hold = 1'b1; n0 = done_cnt;
    @(posedge swclk); #1;
    ap_sel = ApSel; ap_addr = 6'h03; ap_ren = 1'b1;
    @(posedge swclk); #1;
    ap_ren = 1'b0;
    n = 0;
    @(negedge swclk);
    while (!penable && n < 10) begin n++; @(negedge swclk); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (psel !== 1'b0 || penable !== 1'b0 || ap_rdy !== 1'b1 || ap_err !== 1'b0) begin
      bad++; $display("FAIL rst_mid: got %b%b%b%b want 0010", psel, penable, ap_rdy, ap_err); end
    hold = 1'b0;
    @(negedge swclk); rst_n = 1'b1;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    ap_cmd(ApSel, 6'h01, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++; if (obs_rdata !== e.rdata || done_cnt != n0) begin
      bad++; $display("FAIL rst_mid_tar: got %h/%0d want %h/%0d", obs_rdata, done_cnt, e.rdata,
                      n0); end
  endtask

  initial begin
    test_reset();
    test_drw_write();
    test_wrap();
    test_slverr();
    test_abort();
    test_idr_bd();
    test_unsel();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
